uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5208, system clocks per UART bit (9600 bps at 50 MHz); legal range 2..8191.
REQ-002 SHALL have port clk  input  1  system clock; all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req0  input  1  requester 0 byte-send request, held until ack0.
REQ-005 SHALL have port data0  input  8  requester 0 byte, stable while req0 high.
REQ-006 SHALL have port ack0  output  1  one-cycle pulse: data0 latched, req0 may drop.
REQ-007 SHALL have ports req1/data1/ack1 with the same widths and meaning for requester 1.
REQ-008 SHALL have port tx  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  high from grant cycle until the end of the stop bit.
REQ-010 SHALL have port done  output  1  one-cycle pulse on the last cycle of the stop bit.
REQ-011 SHALL have port done_id  output  1  owner of the frame signalled by done.

Function
REQ-012 SHALL hold states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-013 IDLE: when any req is high, SHALL grant one, pulse its ack, latch its data and owner id, assert busy and enter START in the same edge.
REQ-014 Arbitration SHALL be round-robin: with both req high, grant the requester not granted last; with one high, grant it.
REQ-015 Each state SHALL last exactly CLK_DIV cycles, timed by a bit tick that pulses on the last cycle of each bit period.
REQ-016 tx SHALL be 0 in START, data bit n (LSB first) in DATA bit n, 1 in STOP and IDLE; tx SHALL be registered.
REQ-017 DATA SHALL count bits 0..7 with a 3-bit index and leave after bit 7's tick.
REQ-018 On the STOP tick: done pulses, done_id = latched owner, busy drops and the state returns to IDLE.
REQ-019 A pending request SHALL be granted on the cycle after STOP ends (back-to-back frames, no idle gap beyond one cycle).
REQ-020 Requests arriving while busy SHALL be ignored (no ack) until IDLE; no queueing.
REQ-021 The bit-period counter SHALL be held at 0 in IDLE and restart from 0 on each grant.
REQ-022 Frame length SHALL be 10*CLK_DIV cycles (11*CLK_DIV with parity).

Reset
REQ-023 rst_n low SHALL immediately force IDLE, tx=1, busy=0, ack0=ack1=0, done=0, done_id=0, counter=0, bit index=0.
REQ-024 Reset mid-frame SHALL abort the frame without done; the last-granted pointer SHALL reset to requester 1 so requester 0 wins the first tie.

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: PARITY state after DATA, tx = even parity (XOR of the 8 latched bits), one bit period long.
REQ-026 Macro undefined: no PARITY state or logic; DATA goes directly to STOP.

Structure
REQ-027 A shared package SHALL hold the state encoding, the default CLK_DIV value and the data width (8).
REQ-028 The bit-period counter and tick SHALL live in one sub-module, bps_tick_gen (inputs clk, rst_n, enable; output tick).

Verification (CLK_DIV=4, no parity unless stated)
REQ-029 req0=1, data0=8'hA5 -> ack0 one cycle; tx = 0,1,0,1,0,0,1,0,1,1 each 4 cycles; done with done_id=0 after 40 cycles.
REQ-030 req0 and req1 both high from reset -> req0 granted first, req1 granted the cycle after done; done_id 0 then 1.
REQ-031 req0 held high continuously with req1 high -> grants alternate 0,1,0,1 over four frames.
REQ-032 rst_n low at cycle 17 of a frame -> tx=1, busy=0 immediately; no done; next req1 frame completes normally.
REQ-033 UART_TX_PARITY_EN, data0=8'h07 -> parity bit 1, frame 44 cycles; data0=8'h03 -> parity bit 0.
REQ-034 req1 raised during busy, dropped before STOP ends -> no ack1, no second frame.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Purpose     : shared types and constants for the two-requester UART transmit scheduler.
// Latency     : n/a (package only).
// Backpressure: n/a (package only).
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state encoding.
package uart_tx_sched_pkg;

  localparam int DEF_CLK_DIV = 5208;  // 9600 bps from a 50 MHz clock
  localparam int DATA_W      = 8;
  localparam int CNT_W       = 13;    // holds CLK_DIV-1 for CLK_DIV up to 8191

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } state_t;

endpackage

// File: rtl/bps_tick_gen.sv
// Purpose     : bit-period counter; tick marks the last clock of each bit period.
// Latency     : tick is combinational from the counter; counter restarts the cycle after tick.
// Backpressure: none; enable low holds the counter at 0 so the next period starts clean.
// Ports: clk, rst_n (async active-low), enable (frame in progress), tick (period end).
module bps_tick_gen
  import uart_tx_sched_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Purpose     : round-robin scheduler feeding one 8N1 UART transmitter from two byte requesters.
// Latency     : ack the edge after req is seen in IDLE; frame is 10*CLK_DIV cycles (11 with parity).
// Backpressure: requests are only accepted in IDLE; req must be held until ack, nothing is queued.
// Ports: clk, rst_n, req0/data0/ack0, req1/data1/ack1, tx (idle high), busy, done, done_id.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit between DATA and STOP.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              done_id
);

  state_t            state_q, state_nxt;
  logic [2:0]        bit_idx_q, bit_idx_nxt;
  logic [DATA_W-1:0] data_q;
  logic              owner_q;
  logic              last_q;      // requester granted most recently
  logic              grant;
  logic              gnt_id;
  logic              tx_nxt;
  logic              tick;

  bps_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bps_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state_q != ST_IDLE),
    .tick   (tick)
  );

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_STOP) && tick;
  assign done_id = owner_q;

  always_comb begin
    state_nxt   = state_q;
    bit_idx_nxt = bit_idx_q;
    grant       = 1'b0;
    gnt_id      = 1'b0;
    tx_nxt      = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant       = 1'b1;
          // On a tie the requester not served last wins; otherwise the lone requester.
          gnt_id      = (req0 && req1) ? ~last_q : req1;
          state_nxt   = ST_START;
          bit_idx_nxt = 3'd0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_nxt   = ST_DATA;
          bit_idx_nxt = 3'd0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end else begin
            bit_idx_nxt = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // tx is registered, so it is derived from where the FSM is heading.
    case (state_nxt)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = data_q[bit_idx_nxt];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_nxt = ^data_q;
`endif
      default:   tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= 3'd0;
      data_q    <= '0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;     // requester 0 wins the first tie
      tx        <= 1'b1;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      bit_idx_q <= bit_idx_nxt;
      tx        <= tx_nxt;
      ack0      <= grant && !gnt_id;
      ack1      <= grant && gnt_id;
      if (grant) begin
        data_q  <= gnt_id ? data1 : data0;
        owner_q <= gnt_id;
        last_q  <= gnt_id;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Purpose     : directed self-checking bench for uart_tx_sched with CLK_DIV=4.
// Latency     : frames checked cycle by cycle against hand-derived tx patterns.
// Backpressure: requesters hold req until ack; late requests during busy must be ignored.
// Optional feature macro: UART_TX_PARITY_EN enables the parity frames and 11-bit patterns.
module tb_uart_tx_sched;

  localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, tx, busy, done, done_id;

  int n_checks = 0;
  int n_errs   = 0;

  uart_tx_sched #(.CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .data0   (data0),
    .ack0    (ack0),
    .req1    (req1),
    .data1   (data1),
    .ack1    (ack1),
    .tx      (tx),
    .busy    (busy),
    .done    (done),
    .done_id (done_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected tx per bit slot: start, d[0..7], optional even parity, stop.
  function automatic logic [10:0] frame_pat(input logic [7:0] d);
    logic [10:0] p;
    p      = 11'h7FF;
    p[0]   = 1'b0;
    p[8:1] = d;
`ifdef UART_TX_PARITY_EN
    p[9]   = ^d;
`endif
    return p;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at the negedge where an ack is seen (frame cycle 0); id=-1 on timeout.
  task automatic wait_grant(input int limit, output int id);
    id = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ack0) begin id = 0; break; end
      if (ack1) begin id = 1; break; end
    end
  endtask

  // Called at frame cycle 0; ends at the first negedge after the stop bit.
  task automatic check_frame(input logic [10:0] pat, input logic owner);
    for (int c = 0; c < NBITS*CLK_DIV; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("tx_c%0d", c), tx, pat[c/CLK_DIV]);
      check($sformatf("busy_c%0d", c), busy, 1);
      check($sformatf("done_c%0d", c), done, (c == NBITS*CLK_DIV-1));
      if (c > 0) check($sformatf("ack_quiet_c%0d", c), {ack0, ack1}, 0);
      if (c == NBITS*CLK_DIV-1) check("done_id", done_id, owner);
    end
    @(negedge clk);
    check("busy_after_stop", busy, 0);
    check("done_after_stop", done, 0);
    check("tx_after_stop", tx, 1);
  endtask

  initial begin
    int id;
    logic seen;
    logic [10:0] pat_a5;

    // Reset state
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    do_reset();

    // Single frame 0xA5 from requester 0
`ifdef UART_TX_PARITY_EN
    pat_a5 = 11'b10101001010;
`else
    pat_a5 = 11'b01101001010;
`endif
    req0 = 1'b1; data0 = 8'hA5;
    wait_grant(4, id);
    check("a5_grant", id, 0);
    req0 = 1'b0;
    check_frame(pat_a5, 1'b0);

    // Tie from reset: 0 first, then 1 back-to-back
    do_reset();
    req0 = 1'b1; data0 = 8'h3C;
    req1 = 1'b1; data1 = 8'hC3;
    wait_grant(2, id);
    check("tie_first", id, 0);
    req0 = 1'b0;
    check_frame(frame_pat(8'h3C), 1'b0);
    wait_grant(1, id);
    check("tie_second", id, 1);
    req1 = 1'b0;
    check_frame(frame_pat(8'hC3), 1'b1);

    // Both held continuously: grants alternate
    do_reset();
    req0 = 1'b1; data0 = 8'h11;
    req1 = 1'b1; data1 = 8'h22;
    for (int i = 0; i < 4; i++) begin
      wait_grant((i == 0) ? 2 : 1, id);
      check($sformatf("rr_grant%0d", i), id, i % 2);
      if (i == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      check_frame(frame_pat((i % 2) ? 8'h22 : 8'h11), 1'((i % 2)));
    end

    // Reset at frame cycle 17 aborts without done
    do_reset();
    req0 = 1'b1; data0 = 8'h00;
    wait_grant(2, id);
    check("abort_grant", id, 0);
    req0 = 1'b0;
    repeat (17) @(negedge clk);
    check("pre_abort_tx", tx, 0);
    rst_n = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);
    rst_n = 1'b1;
    req1 = 1'b1; data1 = 8'h81;
    wait_grant(2, id);
    check("post_abort_grant", id, 1);
    req1 = 1'b0;
    check_frame(frame_pat(8'h81), 1'b1);

    // Request raised and dropped while busy is ignored
    req0 = 1'b1; data0 = 8'h96;
    wait_grant(2, id);
    check("busy_req_grant", id, 0);
    req0 = 1'b0;
    fork
      check_frame(frame_pat(8'h96), 1'b0);
      begin
        repeat (10) @(negedge clk);
        req1 = 1'b1; data1 = 8'h5A;
        repeat (20) @(negedge clk);
        req1 = 1'b0;
      end
    join
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ack1 || busy) seen = 1'b1;
    end
    check("busy_req_ignored", seen, 0);

`ifdef UART_TX_PARITY_EN
    // Parity: 0x07 -> 1, 0x03 -> 0; 44-cycle frames
    req0 = 1'b1; data0 = 8'h07;
    wait_grant(2, id);
    check("par07_grant", id, 0);
    req0 = 1'b0;
    check_frame(11'b11000001110, 1'b0);
    req0 = 1'b1; data0 = 8'h03;
    wait_grant(2, id);
    check("par03_grant", id, 0);
    req0 = 1'b0;
    check_frame(11'b10000000110, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
